// File: rtl/fm_sb_freeze_seq.sv
// Trigger-driven freeze sequencer for the FM spy buffers.
// Latency: freeze is registered from next-state; it asserts N edges after an accepted trigger (N = post_trig_cycles).
// Backpressure: none; pulse/level control inputs only, every input is acted on in the cycle it is sampled.
//
// Ports:
//   axi_clk, axi_reset        sole clock, asynchronous active-high reset
//   arm, release_frz          single-cycle software pulses (arm from IDLE, release back to IDLE)
//   sw_freeze                 software freeze level, honoured in every state
//   trig_in, trig_en          trigger sources and their per-source qualifiers
//   post_trig_cycles          capture cycles after the trigger, sampled at trigger acceptance
//   freeze_mask               1 = spy buffer exempt from freeze
//   freeze                    registered per-buffer freeze
//   seq_state                 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
//   trig_src                  qualified trigger sources latched at the accepted trigger
//   missed_trig_cnt           saturating count of triggers seen in POST/FROZEN
//
// Optional feature: define FM_SB_FREEZE_SEQ_MISSED_CNT_EN to build the missed-trigger
// counter; otherwise missed_trig_cnt is tied to 0.

module fm_sb_freeze_seq #(
    parameter int SB_N   = 128,
    parameter int TRIG_N = 8,
    parameter int CNT_W  = 16
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              arm,
    input  logic              release_frz,
    input  logic              sw_freeze,
    input  logic [TRIG_N-1:0] trig_in,
    input  logic [TRIG_N-1:0] trig_en,
    input  logic [CNT_W-1:0]  post_trig_cycles,
    input  logic [SB_N-1:0]   freeze_mask,
    output logic [SB_N-1:0]   freeze,
    output logic [1:0]        seq_state,
    output logic [TRIG_N-1:0] trig_src,
    output logic [7:0]        missed_trig_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [TRIG_N-1:0] qual_trig;
    logic              qt;

    assign qual_trig = trig_in & trig_en;
    assign qt        = |qual_trig;
    assign seq_state = state;

    // Release has priority over everything outside IDLE; arm only acts in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (arm) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (release_frz)                   next_state = S_IDLE;
                else if (qt && post_trig_cycles == '0) next_state = S_FROZEN;
                else if (qt)                       next_state = S_POST;
            end
            S_POST: begin
                if (release_frz)                   next_state = S_IDLE;
                else if (cnt == CNT_W'(1))         next_state = S_FROZEN;
            end
            S_FROZEN: begin
                if (release_frz) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            trig_src <= '0;
            freeze   <= '0;
        end else begin
            state  <= next_state;
            // Driven from next_state so the buffers stop writing on the same edge
            // the sequencer enters FROZEN.
            freeze <= ~freeze_mask & {SB_N{sw_freeze | (next_state == S_FROZEN)}};

            if (state == S_ARMED && qt && !release_frz) begin
                trig_src <= qual_trig;
                cnt      <= post_trig_cycles;
            end else if (state == S_POST && cnt != '0) begin
                // Guarded so a zero count can never wrap to all-ones.
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef FM_SB_FREEZE_SEQ_MISSED_CNT_EN
    logic [7:0] missed_q;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            missed_q <= '0;
        end else if (state == S_IDLE && arm) begin
            missed_q <= '0;
        end else if ((state == S_POST || state == S_FROZEN) && qt && missed_q != 8'hFF) begin
            missed_q <= missed_q + 8'd1;
        end
    end

    assign missed_trig_cnt = missed_q;
`else
    assign missed_trig_cnt = '0;
`endif

endmodule

// File: doc/fm_sb_freeze_seq.md
# fm_sb_freeze_seq

Trigger-driven freeze sequencer for the FM spy buffers. It arms on software command, waits for a qualified trigger, and lets the spy buffers keep capturing for a programmable number of post-trigger cycles. It then freezes every unmasked spy buffer until software releases it. It sits in the FM control path next to the spy-buffer control block, and its `freeze` vector is OR-combined downstream with the global software freeze.

## Interface
Parameters:
- `SB_N`, 128, number of spy buffers driven.
- `TRIG_N`, 8, number of trigger sources.
- `CNT_W`, 16, post-trigger counter width.

Ports:
- `axi_clk`  in  1  sole clock.
- `axi_reset`  in  1  asynchronous, active-high reset.
- `arm`  in  1  single-cycle pulse; arms the sequencer.
- `release_frz`  in  1  single-cycle pulse; returns to IDLE.
- `sw_freeze`  in  1  level; software freeze, active in any state.
- `trig_in`  in  TRIG_N  trigger sources, sampled each cycle.
- `trig_en`  in  TRIG_N  per-source enable; 1 = source qualifies.
- `post_trig_cycles`  in  CNT_W  capture cycles after the trigger.
- `freeze_mask`  in  SB_N  1 = buffer exempt from freeze.
- `freeze`  out  SB_N  registered per-buffer freeze.
- `seq_state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 FROZEN.
- `trig_src`  out  TRIG_N  qualified triggers latched at the accepted trigger.
- `missed_trig_cnt`  out  8  saturating count of triggers ignored while in POST or FROZEN.

## Operation
- Qualified trigger: `qt = |(trig_in & trig_en)`.
- IDLE:
  - `arm` → ARMED.
  - `missed_trig_cnt` is cleared on `arm`.
- ARMED:
  - `qt` latches `trig_src <= trig_in & trig_en`.
  - If `post_trig_cycles == 0`, go to FROZEN; otherwise load `cnt <= post_trig_cycles` and go to POST.
- POST:
  - `cnt` decrements each cycle.
  - At `cnt == 1` the next state is FROZEN.
- FROZEN: hold until `release_frz`, then go to IDLE.
- `release_frz` in ARMED or POST aborts to IDLE; `trig_src` is kept.
- `release_frz` in IDLE is ignored.
- `arm` in ARMED, POST or FROZEN is ignored.
- `arm` and `release_frz` in the same cycle: release wins in ARMED, POST and FROZEN; arm acts in IDLE.
- Freeze output is registered from next-state: `freeze <= ~freeze_mask & {SB_N{sw_freeze | (next_state == FROZEN)}}`.
- `freeze_mask` and `sw_freeze` changes appear on `freeze` one cycle later in every state, including FROZEN.
- `post_trig_cycles` is sampled only at trigger acceptance; later changes do not affect a running POST.
- `qt` in POST or FROZEN increments `missed_trig_cnt`, saturating at 255; `trig_src` is unchanged.
- All arithmetic is unsigned, and `cnt` never wraps.

## Timing
- Reset values: state IDLE; `freeze` 0; `trig_src` 0; `missed_trig_cnt` 0; `cnt` 0.
- Reset mid-sequence drops `freeze` immediately (asynchronously) and returns to IDLE.
- A trigger sampled at edge T with `post_trig_cycles = N`:
  - `freeze` and `seq_state == 3` become valid after edge T+N.
  - The buffers therefore write exactly N cycles after the trigger cycle.
  - N = 0 freezes at edge T.
- `release_frz` at edge R: `freeze` deasserts after edge R, unless `sw_freeze` is high.
- Arm-to-ready latency is 1 cycle: a trigger is accepted on the edge after the `arm` edge.
- A trigger coincident with the `arm` edge is not accepted.

## Configuration
- `FM_SB_FREEZE_SEQ_MISSED_CNT_EN` defined: the `missed_trig_cnt` logic is implemented as described.
- Not defined: `missed_trig_cnt` is tied to 0 and the counter is not synthesized. All other behaviour is identical.

## Test plan
- Reset, then `arm`, then `trig_in = 0x04` with `trig_en = 0xFF` and `post_trig_cycles = 5`:
  - `freeze` goes all-ones exactly 5 edges after the trigger edge.
  - `trig_src = 0x04` and `seq_state = 3`.
- `post_trig_cycles = 0` with `freeze_mask` bit 0 and bit 127 set: freeze at the trigger edge; `freeze[0] = freeze[127] = 0`, all other bits 1.
- `trig_en = 0x01` with `trig_in = 0x02` while ARMED: state stays 1 and `freeze = 0`. Then `trig_in = 0x01`: state moves to POST.
- `release_frz` asserted 2 cycles into a POST of 10: state returns to 0 and `freeze` never asserts. Then `arm` together with `release_frz` in IDLE: state becomes 1.
- While FROZEN, apply 300 qualified triggers: `missed_trig_cnt = 255` (0 with the macro undefined). The next `arm` after release clears it to 0.
- `sw_freeze = 1` in IDLE: `freeze = ~freeze_mask` one cycle later. Assert `axi_reset` asynchronously mid-POST: `freeze = 0` and `seq_state = 0` without waiting for a clock edge.
